pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: WAIT_CNT_W, default 8, width of the memory-wait cycle counter.
REQ-002 Parameter: PERF_CNT_W, default 16, width of the stall performance counter.
REQ-003 Ports: clk input 1, the single clock, rising edge active; reset_n input 1, asynchronous active-low reset.
REQ-004 Ports: IF_ID_Rs, IF_ID_Rt input 5 each, source registers of the ID-stage instruction.
REQ-005 Ports: ID_EX_Rs, ID_EX_Rt, ID_EX_Rd input 5 each; ID_EX_MemRead, ID_EX_RegWrite input 1 each; EX-stage instruction fields.
REQ-006 Ports: EX_MEM_RegWrite input 1, EX_MEM_Rd input 5, MEM_WB_RegWrite input 1, MEM_WB_Rd input 5.
REQ-007 Ports: Branch_taken input 1, resolved taken branch or jump in EX; dmem_req input 1, MEM-stage access active; dmem_ready input 1, data memory completes this cycle.
REQ-008 Ports: PC_write, IF_ID_write output 1 each, register enables; IF_ID_flush, ID_EX_flush output 1 each, zero the control bits on the next edge.
REQ-009 Ports: EX_MEM_hold output 1, freezes EX/MEM; MEM_WB_bubble output 1, forces RegWrite=0 and MemtoReg=0 into MEM/WB.
REQ-010 Ports: ForwardA, ForwardB output 2 each, EX operand select; mem_timeout output 1; stall_cycles output PERF_CNT_W.

Function
REQ-011 FSM states are RUN and MEM_WAIT; all control outputs are combinational from the state and the current inputs.
REQ-012 RUN to MEM_WAIT occurs when dmem_req=1 and dmem_ready=0; MEM_WAIT to RUN occurs on the first cycle with dmem_ready=1.
REQ-013 MEM_WAIT with dmem_ready=0 drives PC_write=0, IF_ID_write=0, EX_MEM_hold=1 and MEM_WB_bubble=1, with no flushes.
REQ-014 In that case ID/EX is held through ID_EX_flush=0 and IF_ID_write=0; a Branch_taken is deferred until the cycle after release.
REQ-015 The same freeze applies in RUN whenever dmem_req=1 and dmem_ready=0, so the first miss cycle is also frozen.
REQ-016 Priority order: memory freeze, then Branch_taken, then data hazard stall, then normal flow.
REQ-017 Branch_taken (unfrozen) drives IF_ID_flush=1, ID_EX_flush=1, PC_write=1 and IF_ID_write=1.
REQ-018 Load-use hazard: ID_EX_MemRead=1, ID_EX_Rt!=0 and ID_EX_Rt equal to IF_ID_Rs or IF_ID_Rt.
REQ-019 A load-use hazard drives PC_write=0, IF_ID_write=0 and ID_EX_flush=1, giving a 1-cycle bubble.
REQ-020 Normal flow drives PC_write=1 and IF_ID_write=1, with all flush, hold and bubble signals at 0.
REQ-021 wait_cnt (WAIT_CNT_W bits) increments each cycle in MEM_WAIT, saturates at all-ones and clears on return to RUN.
REQ-022 mem_timeout sets when wait_cnt reaches all-ones and is sticky until reset.
REQ-023 stall_cycles increments by 1 every cycle with PC_write=0 and wraps modulo 2^PERF_CNT_W.
REQ-024 Register 0 never causes a hazard or a forward.

Reset
REQ-025 reset_n low clears the state to RUN and clears wait_cnt, mem_timeout and stall_cycles immediately, without waiting for a clock edge.
REQ-026 While reset_n is low: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, EX_MEM_hold=0, MEM_WB_bubble=1 and ForwardA=ForwardB=00.
REQ-027 Reset asserted during MEM_WAIT abandons the wait; after release the block starts in RUN.

Configuration
REQ-028 Macro PIPELINE_FORWARD_EN defined: ForwardA selects 10 on an EX_MEM_RegWrite match with ID_EX_Rs, else 01 on a MEM_WB_RegWrite match, else 00; ForwardB is the same against ID_EX_Rt.
REQ-029 Macro PIPELINE_FORWARD_EN undefined: ForwardA and ForwardB are tied to 00.
REQ-030 Macro undefined: the data hazard stall also fires when ID_EX_RegWrite matches ID_EX_Rd, or EX_MEM_RegWrite matches EX_MEM_Rd, against IF_ID_Rs or IF_ID_Rt; it stalls exactly as in REQ-019.

Structure
REQ-031 Package mips_pkg holds the FSM state typedef (RUN, MEM_WAIT) and the forward select constants FWD_REG=00, FWD_WB=01 and FWD_MEM=10.
REQ-032 Forwarding comparison is a sub-module named forwarding_unit, instantiated only under PIPELINE_FORWARD_EN.

Verification
REQ-033 Scenario: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1, and stall_cycles increments by 1.
REQ-034 Scenario: Branch_taken=1 in the same cycle as a load-use hazard -> IF_ID_flush=1, ID_EX_flush=1 and PC_write=1.
REQ-035 Scenario: dmem_req=1 with dmem_ready low for 3 cycles -> 3 frozen cycles with MEM_WB_bubble=1, release on the 4th cycle, and stall_cycles increases by 3.
REQ-036 Scenario: dmem_ready held low for 300 cycles -> mem_timeout=1 from cycle 255 onward and it stays 1 after dmem_ready rises.
REQ-037 Scenario: with the macro defined, EX_MEM_RegWrite=1, EX_MEM_Rd=5, MEM_WB_Rd=5, ID_EX_Rs=5 -> ForwardA=10; with EX_MEM_Rd=0 -> ForwardA=01.
REQ-038 Scenario: reset_n pulsed low in mid MEM_WAIT -> counters read 0, the state is RUN and the outputs match REQ-026 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package mips_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register 0 is hardwired to zero, so it never matches as a producer.
    function automatic logic reg_match(input logic [4:0] producer, input logic [4:0] consumer);
        return (producer != 5'd0) && (producer == consumer);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_forwarding_unit.sv
// EX operand forwarding select: the younger EX/MEM result wins over MEM/WB.
module forwarding_unit
    import mips_pkg::*;
(
    input  logic [4:0] ID_EX_Rs,
    input  logic [4:0] ID_EX_Rt,
    input  logic       EX_MEM_RegWrite,
    input  logic [4:0] EX_MEM_Rd,
    input  logic       MEM_WB_RegWrite,
    input  logic [4:0] MEM_WB_Rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (EX_MEM_RegWrite && reg_match(EX_MEM_Rd, ID_EX_Rs)) begin
            fwd_a = FWD_MEM;
        end else if (MEM_WB_RegWrite && reg_match(MEM_WB_Rd, ID_EX_Rs)) begin
            fwd_a = FWD_WB;
        end
        if (EX_MEM_RegWrite && reg_match(EX_MEM_Rd, ID_EX_Rt)) begin
            fwd_b = FWD_MEM;
        end else if (MEM_WB_RegWrite && reg_match(MEM_WB_Rd, ID_EX_Rt)) begin
            fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/forward controller with data-memory wait FSM.
// Define PIPELINE_FORWARD_EN to enable operand forwarding; otherwise RAW hazards stall.
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_CNT_W = 8,
    parameter int PERF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4:0]            IF_ID_Rs,
    input  logic [4:0]            IF_ID_Rt,
    input  logic [4:0]            ID_EX_Rs,
    input  logic [4:0]            ID_EX_Rt,
    input  logic [4:0]            ID_EX_Rd,
    input  logic                  ID_EX_MemRead,
    input  logic                  ID_EX_RegWrite,
    input  logic                  EX_MEM_RegWrite,
    input  logic [4:0]            EX_MEM_Rd,
    input  logic                  MEM_WB_RegWrite,
    input  logic [4:0]            MEM_WB_Rd,
    input  logic                  Branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic                  EX_MEM_hold,
    output logic                  MEM_WB_bubble,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  mem_timeout,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output state_e                state_dbg
);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    mem_timeout_q, mem_timeout_d;
    logic [PERF_CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic       mem_freeze;
    logic       load_use;
    logic       data_hazard;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign load_use = ID_EX_MemRead &&
                      (reg_match(ID_EX_Rt, IF_ID_Rs) || reg_match(ID_EX_Rt, IF_ID_Rt));

`ifdef PIPELINE_FORWARD_EN
    logic unused_ok;
    assign unused_ok   = ^{ID_EX_RegWrite, ID_EX_Rd};
    assign data_hazard = load_use;

    forwarding_unit u_forwarding_unit (
        .ID_EX_Rs        (ID_EX_Rs),
        .ID_EX_Rt        (ID_EX_Rt),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .EX_MEM_Rd       (EX_MEM_Rd),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .MEM_WB_Rd       (MEM_WB_Rd),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );
`else
    logic unused_ok;
    assign unused_ok = ^{MEM_WB_RegWrite, MEM_WB_Rd, ID_EX_Rs};

    // Without forwarding, any in-flight producer of a source register must drain first.
    assign data_hazard = load_use
        || (ID_EX_RegWrite  && (reg_match(ID_EX_Rd,  IF_ID_Rs) || reg_match(ID_EX_Rd,  IF_ID_Rt)))
        || (EX_MEM_RegWrite && (reg_match(EX_MEM_Rd, IF_ID_Rs) || reg_match(EX_MEM_Rd, IF_ID_Rt)));
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    // Next-state: the wait state is held exactly while the memory is frozen.
    always_comb begin
        mem_freeze = 1'b0;
        state_d    = state_q;
        case (state_q)
            RUN: begin
                mem_freeze = dmem_req && !dmem_ready;
                if (mem_freeze) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                mem_freeze = !dmem_ready;
                if (dmem_ready) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        EX_MEM_hold   = 1'b0;
        MEM_WB_bubble = 1'b0;
        ForwardA      = fwd_a;
        ForwardB      = fwd_b;
        if (!reset_n) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EX_flush   = 1'b1;
            MEM_WB_bubble = 1'b1;
            ForwardA      = FWD_REG;
            ForwardB      = FWD_REG;
        end else if (mem_freeze) begin
            // A taken branch is not acted on here; EX keeps presenting it until release.
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            EX_MEM_hold   = 1'b1;
            MEM_WB_bubble = 1'b1;
        end else if (Branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (data_hazard) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_comb begin
        if (state_d == MEM_WAIT) begin
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
        mem_timeout_d  = mem_timeout_q | (&wait_cnt_d);
        stall_cycles_d = stall_cycles_q + (PC_write ? PERF_CNT_W'(0) : PERF_CNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed checks of pipeline_ctrl against a rule-level reference model.
module tb_pipeline_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd;
    logic        ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite;
    logic        Branch_taken, dmem_req, dmem_ready;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold, MEM_WB_bubble;
    logic [1:0]  ForwardA, ForwardB;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    state_e      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_wait;
    int m_wcnt;
    bit m_tmo;
    int m_stalls;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WAIT_CNT_W(8), .PERF_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_Rd(EX_MEM_Rd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_Rd(MEM_WB_Rd),
        .Branch_taken(Branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .EX_MEM_hold(EX_MEM_hold), .MEM_WB_bubble(MEM_WB_bubble),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rm(input logic [4:0] producer, input logic [4:0] consumer);
        return (producer != 0) && (producer == consumer);
    endfunction

    // Expected outputs as {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, hold, bubble, FwdA, FwdB}
    task automatic model_outputs(output logic [9:0] exp_ctrl, output bit frz);
        bit hazard;
        int fa, fb;
        frz = m_wait ? !dmem_ready : (dmem_req && !dmem_ready);
        hazard = ID_EX_MemRead && (rm(ID_EX_Rt, IF_ID_Rs) || rm(ID_EX_Rt, IF_ID_Rt));
        fa = 0;
        fb = 0;
`ifdef PIPELINE_FORWARD_EN
        if (EX_MEM_RegWrite && rm(EX_MEM_Rd, ID_EX_Rs)) fa = 2;
        else if (MEM_WB_RegWrite && rm(MEM_WB_Rd, ID_EX_Rs)) fa = 1;
        if (EX_MEM_RegWrite && rm(EX_MEM_Rd, ID_EX_Rt)) fb = 2;
        else if (MEM_WB_RegWrite && rm(MEM_WB_Rd, ID_EX_Rt)) fb = 1;
`else
        if (ID_EX_RegWrite && (rm(ID_EX_Rd, IF_ID_Rs) || rm(ID_EX_Rd, IF_ID_Rt))) hazard = 1;
        if (EX_MEM_RegWrite && (rm(EX_MEM_Rd, IF_ID_Rs) || rm(EX_MEM_Rd, IF_ID_Rt))) hazard = 1;
`endif
        if (!reset_n)          exp_ctrl = {6'b001101, 4'b0000};
        else if (frz)          exp_ctrl = {6'b000011, fa[1:0], fb[1:0]};
        else if (Branch_taken) exp_ctrl = {6'b111100, fa[1:0], fb[1:0]};
        else if (hazard)       exp_ctrl = {6'b000100, fa[1:0], fb[1:0]};
        else                   exp_ctrl = {6'b110000, fa[1:0], fb[1:0]};
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_wcnt = 0;
        m_tmo = 0;
        m_stalls = 0;
    endtask

    // Compare all outputs for the current inputs, clock once, advance the model.
    task automatic step(input string tag);
        logic [9:0] exp_ctrl;
        bit frz;
        #2;
        model_outputs(exp_ctrl, frz);
        check({tag, "_ctrl"}, {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold,
                               MEM_WB_bubble, ForwardA, ForwardB}, exp_ctrl);
        check({tag, "_stalls"}, stall_cycles, m_stalls);
        check({tag, "_timeout"}, mem_timeout, m_tmo);
        check({tag, "_state"}, state_dbg == MEM_WAIT, m_wait);
        @(posedge clk);
        if (!exp_ctrl[9]) m_stalls = (m_stalls + 1) % 65536;
        m_wait = frz;
        m_wcnt = frz ? ((m_wcnt < 255) ? m_wcnt + 1 : 255) : 0;
        if (m_wcnt == 255) m_tmo = 1;
        #1;
    endtask

    task automatic clear_inputs();
        {IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd} = '0;
        {ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite} = '0;
        {Branch_taken, dmem_req} = '0;
        dmem_ready = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold,
                               MEM_WB_bubble, ForwardA, ForwardB}, 10'b0011010000);
        check({tag, "_stalls"}, stall_cycles, 0);
        check({tag, "_timeout"}, mem_timeout, 0);
        check({tag, "_state"}, state_dbg == MEM_WAIT, 0);
    endtask

    initial begin
        int saved;
        clear_inputs();
        model_reset();

        // Reset state, held low from time 0
        #3;
        check_reset("por");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("normal");

        // Load-use: one bubble, one stall cycle
        saved = m_stalls;
        ID_EX_MemRead = 1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
        step("load_use");
        check("load_use_delta", stall_cycles, saved + 1);
        clear_inputs();
        step("after_load_use");

        // Load-use with r0 never stalls
        ID_EX_MemRead = 1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
        step("load_use_r0");
        clear_inputs();

        // Branch wins over load-use
        ID_EX_MemRead = 1; ID_EX_Rt = 5'd8; IF_ID_Rt = 5'd8; Branch_taken = 1;
        step("branch_over_hazard");
        check("branch_pc_write", PC_write, 1'b1);
        clear_inputs();

        // Three-cycle memory miss, released on the fourth
        saved = m_stalls;
        dmem_req = 1; dmem_ready = 0; Branch_taken = 1;
        for (int c = 0; c < 3; c++) begin
            step("miss3");
        end
        dmem_ready = 1;
        step("miss3_release");
        check("miss3_delta", stall_cycles, saved + 3);
        clear_inputs();
        step("after_miss3");

`ifdef PIPELINE_FORWARD_EN
        EX_MEM_RegWrite = 1; EX_MEM_Rd = 5'd5; MEM_WB_RegWrite = 1; MEM_WB_Rd = 5'd5; ID_EX_Rs = 5'd5;
        #2;
        check("fwd_mem", ForwardA, 2'b10);
        EX_MEM_Rd = 5'd0;
        #1;
        check("fwd_wb", ForwardA, 2'b01);
        step("fwd");
        clear_inputs();
`else
        ID_EX_RegWrite = 1; ID_EX_Rd = 5'd5; IF_ID_Rt = 5'd5;
        step("raw_idex");
        clear_inputs();
        EX_MEM_RegWrite = 1; EX_MEM_Rd = 5'd9; IF_ID_Rs = 5'd9;
        step("raw_exmem");
        clear_inputs();
`endif

        // Long miss: timeout from cycle 255, sticky after release
        dmem_req = 1; dmem_ready = 0;
        for (int c = 0; c < 300; c++) begin
            step("long_miss");
            if (c == 253 || c == 254 || c == 299) check("timeout_edge", mem_timeout, (c + 1) >= 255);
        end
        dmem_ready = 1;
        step("long_release");
        clear_inputs();
        step("after_timeout");
        check("timeout_sticky", mem_timeout, 1'b1);

        // Asynchronous reset in the middle of a wait
        dmem_req = 1; dmem_ready = 0;
        for (int c = 0; c < 3; c++) step("pre_reset_miss");
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("mid_wait_reset");
        model_reset();
        dmem_ready = 1; dmem_req = 0;
        #1;
        reset_n = 1'b1;
        step("post_reset");

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            IF_ID_Rs = 5'($urandom_range(0, 7));
            IF_ID_Rt = 5'($urandom_range(0, 7));
            ID_EX_Rs = 5'($urandom_range(0, 7));
            ID_EX_Rt = 5'($urandom_range(0, 7));
            ID_EX_Rd = 5'($urandom_range(0, 7));
            EX_MEM_Rd = 5'($urandom_range(0, 7));
            MEM_WB_Rd = 5'($urandom_range(0, 7));
            ID_EX_MemRead = ($urandom_range(0, 2) == 0);
            ID_EX_RegWrite = ($urandom_range(0, 1) == 0);
            EX_MEM_RegWrite = ($urandom_range(0, 1) == 0);
            MEM_WB_RegWrite = ($urandom_range(0, 1) == 0);
            Branch_taken = ($urandom_range(0, 5) == 0);
            dmem_req = ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, 2) != 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
